// File: rtl/proc_vec_pkg.sv
// Shared constants for the vector/scalar decode stage: instruction field layout,
// register-bank encoding and scoreboard sizing.
package proc_vec_pkg;

  localparam int REG_ADDR_W  = 3;
  localparam int NUM_REGS    = 1 << REG_ADDR_W;
  localparam int INSTR_W     = 14;

  localparam int MAX_OUT     = 3;
  localparam int STALL_CNT_W = 16;

  localparam int SRC1_MSB    = 5;
  localparam int SRC1_LSB    = 3;
  localparam int SRC2_MSB    = 2;
  localparam int SRC2_LSB    = 0;
  localparam int DEST3_MSB   = 8;
  localparam int DEST3_LSB   = 6;
  localparam int DEST2_MSB   = 9;
  localparam int DEST2_LSB   = 8;
  localparam int OPCODE_MSB  = 13;
  localparam int OPCODE_LSB  = 10;

  typedef enum logic {
    BANK_SCA = 1'b0,
    BANK_VEC = 1'b1
  } bank_e;

  // The short destination form only reaches registers 0..3.
  function automatic logic [REG_ADDR_W-1:0] dest_addr(
    input logic [INSTR_W-1:0] instr,
    input logic               sel_dest
  );
    if (sel_dest) begin
      dest_addr = {1'b0, instr[DEST2_MSB:DEST2_LSB]};
    end else begin
      dest_addr = instr[DEST3_MSB:DEST3_LSB];
    end
  endfunction

endpackage

// File: rtl/pend_counter.sv
// Outstanding-write counter for one register: saturating up/down count with
// clear, status flags and an underflow pulse for writebacks nobody asked for.
module pend_counter #(
  parameter int MAX_OUT = 3,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic one,
  output logic full,
  output logic underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign zero = (count_q == '0);
  assign one  = (count_q == CNT_ONE);
  assign full = (count_q == CNT_MAX);

  // A simultaneous inc cancels the dec, so that case is not an underflow.
  assign underflow = dec & ~inc & zero;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec && !full) begin
      count_d = count_q + CNT_ONE;
    end else if (dec && !inc && !zero) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage hazard scoreboard for 8 vector + 8 scalar registers.
// Optional macro WB_BYPASS_EN lets a same-cycle final writeback clear a source hazard.
module id_scoreboard
  import proc_vec_pkg::*;
#(
  parameter int MAX_OUT     = proc_vec_pkg::MAX_OUT,
  parameter int STALL_CNT_W = proc_vec_pkg::STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [INSTR_W-1:0]     id_instr,
  input  logic                   id_sel_dest,
  input  logic                   id_rdv,
  input  logic                   id_rds,
  input  logic                   id_wrv,
  input  logic                   id_wrs,
  input  logic                   flush,
  input  logic                   wb_valid,
  input  logic                   wb_is_vec,
  input  logic [REG_ADDR_W-1:0]  wb_dir,
  output logic                   issue,
  output logic                   stall,
  output logic [NUM_REGS-1:0]    pend_v,
  output logic [NUM_REGS-1:0]    pend_s,
  output logic                   wb_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic [REG_ADDR_W-1:0] dest;

  logic [NUM_REGS-1:0] inc_v, inc_s, dec_v, dec_s;
  logic [NUM_REGS-1:0] zero_v, zero_s, one_v, one_s, full_v, full_s;
  logic [NUM_REGS-1:0] uf_v, uf_s;
  logic [NUM_REGS-1:0] byp_v, byp_s;
  logic [NUM_REGS-1:0] src_pend_v, src_pend_s;

  logic                   hazard;
  logic                   wb_err_q, wb_err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic unused_opcode;
  assign unused_opcode = ^id_instr[OPCODE_MSB:OPCODE_LSB];

  assign src1 = id_instr[SRC1_MSB:SRC1_LSB];
  assign src2 = id_instr[SRC2_MSB:SRC2_LSB];
  assign dest = dest_addr(id_instr, id_sel_dest);

`ifdef WB_BYPASS_EN
  // The write port commits ahead of the read, so a last outstanding write
  // retiring this cycle no longer blocks readers of that register.
  assign byp_v = dec_v;
  assign byp_s = dec_s;
`else
  assign byp_v = '0;
  assign byp_s = '0;
`endif

  assign src_pend_v = ~zero_v & ~(byp_v & one_v);
  assign src_pend_s = ~zero_s & ~(byp_s & one_s);

  always_comb begin
    hazard = 1'b0;
    if (id_rdv && (src_pend_v[src1] || src_pend_v[src2])) begin
      hazard = 1'b1;
    end
    if (id_rds && src_pend_s[src2]) begin
      hazard = 1'b1;
    end
    if (id_wrv && full_v[dest]) begin
      hazard = 1'b1;
    end
    if (id_wrs && full_s[dest]) begin
      hazard = 1'b1;
    end
  end

  assign issue = id_valid & ~hazard;
  assign stall = id_valid & hazard;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign inc_v[gi] = issue & id_wrv & (dest == REG_ADDR_W'(gi));
      assign inc_s[gi] = issue & id_wrs & (dest == REG_ADDR_W'(gi));
      assign dec_v[gi] = wb_valid & (wb_is_vec == BANK_VEC) & (wb_dir == REG_ADDR_W'(gi));
      assign dec_s[gi] = wb_valid & (wb_is_vec == BANK_SCA) & (wb_dir == REG_ADDR_W'(gi));

      pend_counter #(
        .MAX_OUT (MAX_OUT)
      ) u_cnt_vec (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .inc       (inc_v[gi]),
        .dec       (dec_v[gi]),
        .zero      (zero_v[gi]),
        .one       (one_v[gi]),
        .full      (full_v[gi]),
        .underflow (uf_v[gi])
      );

      pend_counter #(
        .MAX_OUT (MAX_OUT)
      ) u_cnt_sca (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .inc       (inc_s[gi]),
        .dec       (dec_s[gi]),
        .zero      (zero_s[gi]),
        .one       (one_s[gi]),
        .full      (full_s[gi]),
        .underflow (uf_s[gi])
      );
    end
  endgenerate

  assign pend_v = ~zero_v;
  assign pend_s = ~zero_s;

  always_comb begin
    wb_err_d    = wb_err_q | (|uf_v) | (|uf_s);
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // flush only touches the counters; error and stall statistics survive it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      wb_err_q    <= wb_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wb_err    = wb_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule
